// File: rtl/lane_scroll_renderer.sv
// Per-pixel lane/object colour generator for the frogger playfield, 1-cycle registered output.
// Optional macro LANE_DIVIDER_EN draws a white divider on the first row of every lane.
module lane_scroll_renderer #(
  parameter int NUM_LANES       = 8,
  parameter int LANE_H          = 60,
  parameter int H_ACTIVE        = 640,
  parameter int OBJ_PERIOD_LOG2 = 7,
  parameter int OBJ_LEN         = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [9:0]  next_x,
  input  logic [9:0]  next_y,
  output logic [7:0]  color_out,
  output logic [3:0]  lane_idx,
  output logic [15:0] frame_count
);

  localparam int P = OBJ_PERIOD_LOG2;

  localparam logic [7:0] COL_CAR   = 8'b11100000;
  localparam logic [7:0] COL_ROAD  = 8'b01001001;
  localparam logic [7:0] COL_LOG   = 8'b10001000;
  localparam logic [7:0] COL_WATER = 8'b00000011;

  logic [P-1:0] offset_q [NUM_LANES];
  logic [P-1:0] offset_d [NUM_LANES];
  logic [15:0]  frame_count_q, frame_count_d;
  logic [7:0]   color_q, color_d;
  logic [3:0]   lane_q, lane_d;

  logic         in_lane;
  logic         odd_lane;
  logic [P-1:0] sel_off;
  logic [P-1:0] pos;
`ifdef LANE_DIVIDER_EN
  logic         first_row;
`endif

  // Lane i scrolls by (i mod 4)+1 pixels per accepted tick; offsets wrap at the pattern period.
  always_comb begin
    frame_count_d = frame_count_q;
    for (int i = 0; i < NUM_LANES; i++) offset_d[i] = offset_q[i];
    if (frame_tick && enable) begin
      frame_count_d = frame_count_q + 16'd1;
      for (int i = 0; i < NUM_LANES; i++) offset_d[i] = offset_q[i] + P'(i % 4 + 1);
    end
  end

  always_comb begin
    lane_d   = 4'hF;
    in_lane  = 1'b0;
    odd_lane = 1'b0;
    sel_off  = '0;
`ifdef LANE_DIVIDER_EN
    first_row = 1'b0;
`endif
    for (int i = 0; i < NUM_LANES; i++) begin
      if (int'(next_y) >= i * LANE_H && int'(next_y) < (i + 1) * LANE_H) begin
        lane_d   = 4'(i);
        in_lane  = 1'b1;
        odd_lane = (i % 2) == 1;
        sel_off  = offset_q[i];
`ifdef LANE_DIVIDER_EN
        first_row = int'(next_y) == i * LANE_H;
`endif
      end
    end
  end

  // Roads move right (subtract offset), water moves left (add offset).
  always_comb begin
    pos     = odd_lane ? (next_x[P-1:0] + sel_off) : (next_x[P-1:0] - sel_off);
    color_d = 8'h00;
    if (in_lane && int'(next_x) < H_ACTIVE) begin
      if (odd_lane) color_d = (int'(pos) < OBJ_LEN) ? COL_LOG : COL_WATER;
      else          color_d = (int'(pos) < OBJ_LEN) ? COL_CAR : COL_ROAD;
`ifdef LANE_DIVIDER_EN
      if (first_row) color_d = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) offset_q[i] <= '0;
      frame_count_q <= '0;
      color_q       <= '0;
      lane_q        <= 4'hF;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) offset_q[i] <= offset_d[i];
      frame_count_q <= frame_count_d;
      color_q       <= color_d;
      lane_q        <= lane_d;
    end
  end

  assign color_out   = color_q;
  assign lane_idx    = lane_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/lane_scroll_renderer.md
Name: lane_scroll_renderer

Overview:
- Per-pixel colour generator for the frogger playfield.
- Sits between the VGA driver's next_x/next_y outputs and its color_in input.
- Divides the screen into NUM_LANES horizontal lanes. Even lanes are roads carrying cars; odd lanes are water carrying logs.
- Objects scroll at a per-lane speed, advanced once per frame. Registered output, 1-cycle latency.

Parameters:
- NUM_LANES, 8, number of horizontal lanes drawn from row 0 downward.
- LANE_H, 60, lane height in pixel rows.
- H_ACTIVE, 640, visible width; columns >= H_ACTIVE are blanked.
- OBJ_PERIOD_LOG2, 7, object pattern period = 2^OBJ_PERIOD_LOG2 pixels (128). Offsets wrap naturally at this width.
- OBJ_LEN, 64, object length in pixels; must be < 2^OBJ_PERIOD_LOG2.

Ports:
- clock  in  1  25 MHz pixel clock (same clock as the VGA driver).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when high, frame_tick advances lane offsets; when low, the playfield is frozen.
- frame_tick  in  1  single-cycle pulse, once per frame, issued during vertical blanking.
- next_x  in  10  column of the next pixel.
- next_y  in  10  row of the next pixel.
- color_out  out  8  RRRGGGBB colour for (next_x, next_y) of the previous cycle.
- lane_idx  out  4  registered lane index of the pixel in color_out; 15 when outside the lanes.
- frame_count  out  16  count of accepted frame ticks.

Behaviour:
- Reset (asynchronous, any time): color_out=0, lane_idx=15, frame_count=0, all lane offsets=0. Takes effect immediately, including mid-frame.
- Lane decode: lane = next_y / LANE_H for next_y < NUM_LANES*LANE_H; otherwise the pixel is out-of-lane. A constant divide or a compare chain is acceptable; the decode is combinational.
- Offset register per lane: OBJ_PERIOD_LOG2 bits wide.
- Lane speed: speed_i = (i mod 4) + 1 pixels per frame.
- Offset update: on a clock edge with frame_tick=1 and enable=1, offset_i <= offset_i + speed_i (mod 2^OBJ_PERIOD_LOG2), and frame_count increments (wraps at 65535 to 0).
- frame_tick with enable=0: no change to offsets or frame_count.
- Pattern position, using the low OBJ_PERIOD_LOG2 bits:
  - Even lane (moves right): p = (next_x - offset_i).
  - Odd lane (moves left): p = (next_x + offset_i).
  - The pixel is an object when p < OBJ_LEN.
- Colour selection, registered on each clock:
  - next_x >= H_ACTIVE or out-of-lane row: 8'h00.
  - Even lane, object (car): 8'b11100000. Even lane, background (road): 8'b01001001.
  - Odd lane, object (log): 8'b10001000. Odd lane, background (water): 8'b00000011.
- Latency: color_out and lane_idx reflect the next_x/next_y sampled on the preceding edge (exactly 1 cycle).
- A frame_tick in the same cycle as a pixel lookup: the lookup uses the old offsets; the new offsets apply from the following cycle.

Optional Feature:
- Macro: LANE_DIVIDER_EN.
- Defined: the first row of each lane (next_y mod LANE_H == 0, within the lanes) outputs 8'hFF for all columns < H_ACTIVE. This overrides object and background colours.
- Undefined: no divider rows; the colour rules above apply unchanged.

Test Plan:
- Reset deassert, enable=1, no ticks; next_y=10, next_x=0, then 63, then 64 -> color_out 8'hE0, 8'hE0, 8'h49 one cycle after each; lane_idx=0.
- One frame_tick; lane 0 (next_y=10): x=0 -> 8'h49, x=1 -> 8'hE0, x=64 -> 8'hE0. Lane 1 (next_y=70, speed 2): x=0 -> 8'h88, x=62 -> 8'h03. frame_count=1.
- 32 frame_ticks; lane 3 (next_y=200, speed 4, offset wraps to 0): x=0 -> 8'h88, x=64 -> 8'h03.
- enable=0 with 10 frame_ticks -> offsets and frame_count unchanged; next_x=700 -> 8'h00; next_y=500 -> 8'h00 and lane_idx=15.
- After 5 ticks, assert reset mid-line -> color_out=0 without a clock edge, frame_count=0. After release, lane 0 at x=0 -> 8'hE0.
- LANE_DIVIDER_EN defined: next_y=60, x=100 -> 8'hFF; next_y=61, x=0 -> 8'h88; next_y=60, x=650 -> 8'h00.
